// File: rtl/me_pkg.sv
// Shared constants and FSM encoding for the reference-window row fetcher.
package me_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned ROW_PIX = 23;
  localparam int unsigned ROW_W   = PIX_W * ROW_PIX;
  localparam int unsigned OUT_W   = 128;
  localparam int unsigned IDX_W   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/rd_valid_pipe.sv
// Valid shift register that tracks SRAM reads still in flight.
module rd_valid_pipe
  import me_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  output logic tail_o,
  output logic any_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail_o = pipe_q[DEPTH-1];
  assign any_o  = |pipe_q;

endmodule

// File: rtl/ref_row_fetch.sv
// Fetches one strided search-window row per cycle from the reference SRAM and
// presents each returned row on a registered bus with a valid strobe and index.
module ref_row_fetch
  import me_pkg::*;
#(
  parameter int unsigned ROWS   = 23,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] row_stride_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [ROW_W-1:0]  mem_rd_data_i,
  output logic [ROW_W-1:0]  data_out,
  output logic              row_valid_o,
  output logic [IDX_W-1:0]  row_idx_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROWS - 1);

  fetch_state_e      state_q;
  logic [IDX_W-1:0]  issue_cnt_q;
  logic [IDX_W-1:0]  cap_cnt_q;
  logic [ADDR_W-1:0] stride_q;
  logic              tail;
  logic              in_flight;

  rd_valid_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_valid_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (mem_rd_en_o),
    .tail_o  (tail),
    .any_o   (in_flight)
  );

  // mem_addr_o doubles as the running address register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_addr_o  <= '0;
      stride_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StIssue;
            busy_o      <= 1'b1;
            mem_rd_en_o <= 1'b1;
            mem_addr_o  <= base_addr_i;
            stride_q    <= row_stride_i;
            issue_cnt_q <= '0;
          end
        end
        StIssue: begin
          if (issue_cnt_q == LastIdx) begin
            mem_rd_en_o <= 1'b0;
            state_q     <= StDrain;
          end else begin
            mem_addr_o  <= mem_addr_o + stride_q;
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
        end
        StDrain: begin
          // Pipe empty implies the final row was captured on the previous edge.
          if (!in_flight) begin
            done_o  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_out    <= '0;
      row_valid_o <= 1'b0;
      row_idx_o   <= '0;
      cap_cnt_q   <= '0;
    end else begin
      row_valid_o <= tail;
      if (state_q == StIdle && start_i) begin
        cap_cnt_q <= '0;
      end else if (tail) begin
        data_out  <= mem_rd_data_i;
        row_idx_o <= cap_cnt_q;
        cap_cnt_q <= cap_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ref_row_fetch.sv
// Directed bench for ref_row_fetch: two instances (23 rows/lat 1, 4 rows/lat 3).
module tb_ref_row_fetch;
  import me_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;
  logic [9:0] base_a, stride_a, base_b, stride_b;
  logic busy_a, done_a, rd_en_a, valid_a, busy_b, done_b, rd_en_b, valid_b;
  logic [9:0] addr_a, addr_b;
  logic [ROW_W-1:0] rd_data_a, rd_data_b, data_a, data_b;
  logic [7:0] idx_a, idx_b;

  ref_row_fetch #(.ROWS(23), .ADDR_W(10), .RD_LAT(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .base_addr_i(base_a),
    .row_stride_i(stride_a), .busy_o(busy_a), .done_o(done_a), .mem_rd_en_o(rd_en_a),
    .mem_addr_o(addr_a), .mem_rd_data_i(rd_data_a), .data_out(data_a),
    .row_valid_o(valid_a), .row_idx_o(idx_a)
  );

  ref_row_fetch #(.ROWS(4), .ADDR_W(10), .RD_LAT(3)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .base_addr_i(base_b),
    .row_stride_i(stride_b), .busy_o(busy_b), .done_o(done_b), .mem_rd_en_o(rd_en_b),
    .mem_addr_o(addr_b), .mem_rd_data_i(rd_data_b), .data_out(data_b),
    .row_valid_o(valid_b), .row_idx_o(idx_b)
  );

  // SRAM models: row = address low byte replicated; 0xEE when no read was issued.
  logic [ROW_W-1:0] mem_a_q;
  logic [ROW_W-1:0] mem_b_q [3];
  always @(posedge clk) begin
    mem_a_q    <= rd_en_a ? {ROW_PIX{addr_a[7:0]}} : {ROW_PIX{8'hEE}};
    mem_b_q[0] <= rd_en_b ? {ROW_PIX{addr_b[7:0]}} : {ROW_PIX{8'hEE}};
    mem_b_q[1] <= mem_b_q[0];
    mem_b_q[2] <= mem_b_q[1];
  end
  assign rd_data_a = mem_a_q;
  assign rd_data_b = mem_b_q[2];

  logic cur_sel;
  logic obs_busy, obs_done, obs_rd_en, obs_valid;
  logic [9:0] obs_addr;
  logic [ROW_W-1:0] obs_data;
  logic [7:0] obs_idx;
  always_comb begin
    obs_busy  = cur_sel ? busy_b  : busy_a;
    obs_done  = cur_sel ? done_b  : done_a;
    obs_rd_en = cur_sel ? rd_en_b : rd_en_a;
    obs_valid = cur_sel ? valid_b : valid_a;
    obs_addr  = cur_sel ? addr_b  : addr_a;
    obs_data  = cur_sel ? data_b  : data_a;
    obs_idx   = cur_sel ? idx_b   : idx_a;
  end

  typedef struct {
    logic       sel;
    logic [9:0] base;
    logic [9:0] stride;
    int         ign;
    logic [9:0] exp_addr1;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [5];
  logic [ROW_W-1:0] exp_data [2];
  logic [7:0] exp_idx [2];
  int n_checks = 0;
  int n_pass = 0;
  int cur_cyc = 0;

  task automatic chk(input string name, input logic [ROW_W-1:0] act,
                     input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d sel=%0d: got %h want %h", name, cur_cyc, cur_sel, act, exp);
  endtask

  task automatic drive_start(input logic sel, input logic s, input logic [9:0] b,
                             input logic [9:0] st);
    if (sel) begin
      start_b = s; base_b = b; stride_b = st;
    end else begin
      start_a = s; base_a = b; stride_a = st;
    end
  endtask

  // Must be called just after a negedge; start is sampled on the next posedge (cycle 0).
  task automatic run_fetch(input int vi);
    vec_t v;
    int rows, lat, d, r;
    logic [7:0] b;
    v = vecs[vi];
    rows = v.sel ? 4 : 23;
    lat = v.sel ? 3 : 1;
    d = rows + lat + 2;
    cur_sel = v.sel;
    drive_start(v.sel, 1'b1, v.base, v.stride);
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      cur_cyc = c;
      if (c >= lat + 2 && c <= rows + lat + 1) begin
        r = c - lat - 2;
        b = 8'(v.base + r * v.stride);
        exp_data[v.sel] = {ROW_PIX{b}};
        exp_idx[v.sel] = 8'(r);
      end
      chk("rd_en", obs_rd_en, c <= rows);
      if (c <= rows) chk("addr", obs_addr, 10'(v.base + (c - 1) * v.stride));
      chk("row_valid", obs_valid, c >= lat + 2 && c <= rows + lat + 1);
      chk("data_out", obs_data, exp_data[v.sel]);
      chk("row_idx", obs_idx, exp_idx[v.sel]);
      chk("busy", obs_busy, c <= d);
      chk("done", obs_done, c == d);
      if (c == 2) chk("tbl_addr1", obs_addr, v.exp_addr1);
      if (c == lat + 2) chk("tbl_first_row", obs_data, {ROW_PIX{v.exp_first}});
      if (c == rows + lat + 1) chk("tbl_last_row", obs_data, {ROW_PIX{v.exp_last}});
      if (c == v.ign) drive_start(v.sel, 1'b1, 10'h100, 10'h040);
      else drive_start(v.sel, 1'b0, v.base, v.stride);
    end
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, base: 10'h010, stride: 10'h020, ign: 10,
                exp_addr1: 10'h030, exp_first: 8'h10, exp_last: 8'hD0};
    vecs[1] = '{sel: 1'b0, base: 10'h3F0, stride: 10'h020, ign: 0,
                exp_addr1: 10'h010, exp_first: 8'hF0, exp_last: 8'hB0};
    vecs[2] = '{sel: 1'b0, base: 10'h155, stride: 10'h001, ign: 26,
                exp_addr1: 10'h156, exp_first: 8'h55, exp_last: 8'h6B};
    vecs[3] = '{sel: 1'b0, base: 10'h000, stride: 10'h3FF, ign: 0,
                exp_addr1: 10'h3FF, exp_first: 8'h00, exp_last: 8'hEA};
    vecs[4] = '{sel: 1'b1, base: 10'h020, stride: 10'h008, ign: 0,
                exp_addr1: 10'h028, exp_first: 8'h20, exp_last: 8'h38};

    rst_n = 1'b0;
    cur_sel = 1'b0;
    drive_start(1'b0, 1'b0, 10'h0, 10'h0);
    drive_start(1'b1, 1'b0, 10'h0, 10'h0);
    for (int i = 0; i < 2; i++) begin
      exp_data[i] = '0;
      exp_idx[i] = '0;
    end
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      cur_sel = s[0];
      #1;
      chk("rst_busy", obs_busy, 1'b0);
      chk("rst_done", obs_done, 1'b0);
      chk("rst_rd_en", obs_rd_en, 1'b0);
      chk("rst_addr", obs_addr, '0);
      chk("rst_valid", obs_valid, 1'b0);
      chk("rst_data", obs_data, '0);
      chk("rst_idx", obs_idx, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive entries also exercise back-to-back starts and data hold.
    for (int i = 0; i < 5; i++) run_fetch(i);

    // Reset asserted mid-fetch.
    @(negedge clk);
    cur_sel = 1'b0;
    drive_start(1'b0, 1'b1, 10'h080, 10'h004);
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      drive_start(1'b0, 1'b0, 10'h080, 10'h004);
    end
    @(negedge clk);
    cur_cyc = 12;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", obs_busy, 1'b0);
    chk("midrst_rd_en", obs_rd_en, 1'b0);
    chk("midrst_addr", obs_addr, '0);
    chk("midrst_valid", obs_valid, 1'b0);
    chk("midrst_data", obs_data, '0);
    chk("midrst_idx", obs_idx, '0);
    for (int i = 0; i < 2; i++) begin
      exp_data[i] = '0;
      exp_idx[i] = '0;
    end
    repeat (2) begin
      @(negedge clk);
      chk("midrst_done", obs_done, 1'b0);
      chk("midrst_busy_hold", obs_busy, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_fetch(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
